// File: rtl/regfile_wb_if.sv
// Write-back bus between the ALU/memory requesters, the issue stage and the
// register-file write arbiter.
interface regfile_wb_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  alu_valid;
  logic [ADDR_WIDTH-1:0] alu_rd;
  logic [WIDTH-1:0]      alu_data;
  logic                  alu_ready;

  logic                  mem_valid;
  logic [ADDR_WIDTH-1:0] mem_rd;
  logic [WIDTH-1:0]      mem_data;
  logic                  mem_ready;

  logic                  claim_valid;
  logic [ADDR_WIDTH-1:0] claim_rd;
  logic [ADDR_WIDTH-1:0] issue_rs1;
  logic [ADDR_WIDTH-1:0] issue_rs2;
  logic [ADDR_WIDTH-1:0] issue_rd;
  logic                  stall;

  logic                  RegWrite;
  logic [ADDR_WIDTH-1:0] Rd;
  logic [WIDTH-1:0]      WriteData;
  logic                  sb_err;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    output claim_valid, claim_rd, issue_rs1, issue_rs2, issue_rd,
    input  alu_ready, mem_ready, stall, RegWrite, Rd, WriteData, sb_err
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    input  claim_valid, claim_rd, issue_rs1, issue_rs2, issue_rd,
    output alu_ready, mem_ready, stall, RegWrite, Rd, WriteData, sb_err
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between ALU and memory
// write-back, and tracks registers with an outstanding load for issue stalls.
module regfile_wb_arbiter #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int MAX_WAIT   = 3
) (
  input  logic         clk,
  input  logic         rst,
  regfile_wb_if.slave  bus
);
  localparam int NREG = 2 ** ADDR_WIDTH;
  localparam int CW   = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_LOAD = CW'(MAX_WAIT);

  // Counts down the cycles the ALU may still be refused; zero means it overrides memory.
  logic [CW-1:0]   wait_left;
  logic            alu_ovr;
  logic            grant_alu;
  logic            grant_mem;
  logic            claim_set;
  logic            claim_err;
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;

  assign alu_ovr   = (wait_left == '0);
  assign grant_alu = !rst && bus.alu_valid && (!bus.mem_valid || alu_ovr);
  assign grant_mem = !rst && bus.mem_valid && (!bus.alu_valid || !alu_ovr);

  assign bus.alu_ready = grant_alu;
  assign bus.mem_ready = grant_mem;

  always_ff @(posedge clk) begin
    if (rst || !bus.alu_valid || grant_alu) begin
      wait_left <= WAIT_LOAD;
    end else if (!alu_ovr) begin
      wait_left <= wait_left - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.RegWrite  <= 1'b0;
      bus.Rd        <= '0;
      bus.WriteData <= '0;
    end else if (grant_alu) begin
      bus.RegWrite  <= (bus.alu_rd != '0);
      bus.Rd        <= bus.alu_rd;
      bus.WriteData <= bus.alu_data;
    end else if (grant_mem) begin
      bus.RegWrite  <= (bus.mem_rd != '0);
      bus.Rd        <= bus.mem_rd;
      bus.WriteData <= bus.mem_data;
    end else begin
      bus.RegWrite  <= 1'b0;
    end
  end

  assign claim_set = bus.claim_valid && (bus.claim_rd != '0);
  // A claim landing on a register whose load retires this same cycle is legal.
  assign claim_err = claim_set && busy[bus.claim_rd] &&
                     !(grant_mem && (bus.mem_rd == bus.claim_rd));

  always_comb begin
    busy_nxt = busy;
    if (grant_mem) begin
      busy_nxt[bus.mem_rd] = 1'b0;
    end
    if (claim_set) begin
      busy_nxt[bus.claim_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy       <= '0;
      bus.sb_err <= 1'b0;
    end else begin
      busy <= busy_nxt;
      if (claim_err) begin
        bus.sb_err <= 1'b1;
      end
    end
  end

  assign bus.stall = busy[bus.issue_rs1] | busy[bus.issue_rs2] | busy[bus.issue_rd];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed, table-driven bench for regfile_wb_arbiter plus hand-written
// sequences for priority override, scoreboard and reset corner cases.
module tb_regfile_wb_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  regfile_wb_if #(.WIDTH(32), .ADDR_WIDTH(5)) bus ();

  regfile_wb_arbiter #(.WIDTH(32), .ADDR_WIDTH(5), .MAX_WAIT(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] md;
    logic        exp_ar;
    logic        exp_mr;
    logic        exp_we;
    logic [4:0]  exp_rd;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alu_valid   = 1'b0;
    bus.alu_rd      = '0;
    bus.alu_data    = '0;
    bus.mem_valid   = 1'b0;
    bus.mem_rd      = '0;
    bus.mem_data    = '0;
    bus.claim_valid = 1'b0;
    bus.claim_rd    = '0;
    bus.issue_rs1   = '0;
    bus.issue_rs2   = '0;
    bus.issue_rd    = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b1, 5'd5,  32'hDEADBEEF};
    vecs[1] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd12, 32'hA5A50001, 1'b0, 1'b1, 1'b1, 5'd12, 32'hA5A50001};
    vecs[2] = '{1'b1, 5'd3,  32'h33,       1'b1, 5'd7,  32'h77,       1'b0, 1'b1, 1'b1, 5'd7,  32'h77};
    vecs[3] = '{1'b1, 5'd0,  32'h1234,     1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b0, 5'd0,  32'h1234};
    vecs[4] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h55,       1'b0, 1'b1, 1'b0, 5'd0,  32'h55};
    vecs[5] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 5'd0,  32'h55};

    // Reset with both requesters asserting: nothing may be accepted.
    idle_inputs();
    rst = 1'b1;
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd2;
    bus.mem_valid = 1'b1;
    bus.mem_rd    = 5'd6;
    tick();
    tick();
    chk("rst_alu_ready", {31'b0, bus.alu_ready}, 32'd0);
    chk("rst_mem_ready", {31'b0, bus.mem_ready}, 32'd0);
    chk("rst_regwrite",  {31'b0, bus.RegWrite},  32'd0);
    chk("rst_rd",        {27'b0, bus.Rd},        32'd0);
    chk("rst_wdata",     bus.WriteData,          32'd0);
    chk("rst_sb_err",    {31'b0, bus.sb_err},    32'd0);
    chk("rst_stall",     {31'b0, bus.stall},     32'd0);
    idle_inputs();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      bus.alu_valid = vecs[i].av;
      bus.alu_rd    = vecs[i].ard;
      bus.alu_data  = vecs[i].ad;
      bus.mem_valid = vecs[i].mv;
      bus.mem_rd    = vecs[i].mrd;
      bus.mem_data  = vecs[i].md;
      #1;
      chk($sformatf("vec%0d_alu_ready", i), {31'b0, bus.alu_ready}, {31'b0, vecs[i].exp_ar});
      chk($sformatf("vec%0d_mem_ready", i), {31'b0, bus.mem_ready}, {31'b0, vecs[i].exp_mr});
      tick();
      idle_inputs();
      chk($sformatf("vec%0d_regwrite", i), {31'b0, bus.RegWrite}, {31'b0, vecs[i].exp_we});
      chk($sformatf("vec%0d_rd", i),       {27'b0, bus.Rd},       {27'b0, vecs[i].exp_rd});
      chk($sformatf("vec%0d_wdata", i),    bus.WriteData,         vecs[i].exp_wd);
      tick();
      chk($sformatf("vec%0d_idle_we", i),  {31'b0, bus.RegWrite}, 32'd0);
      chk($sformatf("vec%0d_hold_rd", i),  {27'b0, bus.Rd},       {27'b0, vecs[i].exp_rd});
    end

    // Continuous contention: memory wins three beats, then the ALU, and the cycle repeats.
    for (int i = 0; i < 8; i++) begin
      logic alu_turn;
      alu_turn      = ((i % 4) == 3);
      bus.alu_valid = 1'b1;
      bus.alu_rd    = 5'd3;
      bus.alu_data  = 32'h33;
      bus.mem_valid = 1'b1;
      bus.mem_rd    = 5'd7;
      bus.mem_data  = 32'h100 + 32'(i);
      #1;
      chk($sformatf("cont%0d_alu_ready", i), {31'b0, bus.alu_ready}, {31'b0, alu_turn});
      chk($sformatf("cont%0d_mem_ready", i), {31'b0, bus.mem_ready}, {31'b0, !alu_turn});
      tick();
      chk($sformatf("cont%0d_rd", i),    {27'b0, bus.Rd}, alu_turn ? 32'd3 : 32'd7);
      chk($sformatf("cont%0d_wdata", i), bus.WriteData,   alu_turn ? 32'h33 : 32'h100 + 32'(i));
    end
    idle_inputs();
    tick();

    // Load to x9: stall while outstanding, including the retiring cycle.
    bus.claim_valid = 1'b1;
    bus.claim_rd    = 5'd9;
    tick();
    idle_inputs();
    bus.issue_rs2 = 5'd9;
    #1;
    chk("ld9_stall_busy", {31'b0, bus.stall}, 32'd1);
    tick();
    bus.mem_valid = 1'b1;
    bus.mem_rd    = 5'd9;
    bus.mem_data  = 32'h99;
    #1;
    chk("ld9_mem_ready", {31'b0, bus.mem_ready}, 32'd1);
    chk("ld9_stall_retire", {31'b0, bus.stall}, 32'd1);
    tick();
    bus.mem_valid = 1'b0;
    #1;
    chk("ld9_stall_clear", {31'b0, bus.stall},    32'd0);
    chk("ld9_regwrite",    {31'b0, bus.RegWrite}, 32'd1);
    chk("ld9_rd",          {27'b0, bus.Rd},       32'd9);
    chk("ld9_wdata",       bus.WriteData,         32'h99);
    idle_inputs();

    // Claims of x0 are ignored and never stall or flag an error.
    bus.claim_valid = 1'b1;
    bus.claim_rd    = 5'd0;
    tick();
    tick();
    bus.claim_valid = 1'b0;
    bus.issue_rs1   = 5'd0;
    #1;
    chk("x0_stall",  {31'b0, bus.stall},  32'd0);
    chk("x0_sb_err", {31'b0, bus.sb_err}, 32'd0);

    // Re-claim of x4 while its load retires is legal; a later bare re-claim is not.
    idle_inputs();
    bus.claim_valid = 1'b1;
    bus.claim_rd    = 5'd4;
    tick();
    bus.mem_valid = 1'b1;
    bus.mem_rd    = 5'd4;
    bus.mem_data  = 32'h44;
    #1;
    chk("x4_mem_ready", {31'b0, bus.mem_ready}, 32'd1);
    tick();
    idle_inputs();
    bus.issue_rd = 5'd4;
    #1;
    chk("x4_busy_kept", {31'b0, bus.stall},  32'd1);
    chk("x4_no_err",    {31'b0, bus.sb_err}, 32'd0);
    bus.claim_valid = 1'b1;
    bus.claim_rd    = 5'd4;
    tick();
    bus.claim_valid = 1'b0;
    #1;
    chk("x4_err_set", {31'b0, bus.sb_err}, 32'd1);
    tick();
    chk("x4_err_sticky", {31'b0, bus.sb_err}, 32'd1);
    chk("x4_still_busy", {31'b0, bus.stall},  32'd1);

    // Reset in the middle of contention with x4 still outstanding.
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd1;
    bus.alu_data  = 32'hAA;
    bus.mem_valid = 1'b1;
    bus.mem_rd    = 5'd2;
    bus.mem_data  = 32'hBB;
    rst = 1'b1;
    #1;
    chk("mid_rst_alu_ready", {31'b0, bus.alu_ready}, 32'd0);
    chk("mid_rst_mem_ready", {31'b0, bus.mem_ready}, 32'd0);
    tick();
    idle_inputs();
    bus.issue_rd = 5'd4;
    rst = 1'b0;
    #1;
    chk("mid_rst_stall",    {31'b0, bus.stall},    32'd0);
    chk("mid_rst_regwrite", {31'b0, bus.RegWrite}, 32'd0);
    chk("mid_rst_sb_err",   {31'b0, bus.sb_err},   32'd0);
    tick();
    chk("post_rst_regwrite", {31'b0, bus.RegWrite}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
